// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers a mono 16-bit sample stream in a small FIFO and
// transmits each sample on both slots of a standard I2S frame.
// BCLK and LRCLK are derived by dividing the system clock.
// All serial state advances on BCLK falling edges.
module i2s_tx_serializer #(
   parameter int SLEN       = 16,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic [SLEN-1:0] i_sample,
   output logic            o_ready,
   output logic            o_bclk,
   output logic            o_lrclk,
   output logic            o_sdata,
   output logic            o_underrun,
   output logic            o_overflow
);

   localparam int FRAME = 2 * SLEN;
   localparam int SW    = $clog2(FRAME);
   localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME - 1);
   localparam logic [SW-1:0] SLOT_R    = SW'(SLEN);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   logic [DW-1:0]   div_cnt_r;
   logic            bclk_r;
   logic            lrclk_r;
   logic [SW-1:0]   slot_r;
   logic [FRAME:0]  shift_r;
   logic [SLEN-1:0] last_r;
   logic            underrun_r;
   logic            overflow_r;
   logic            ready_r;
   logic [SLEN-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic            div_tick_s;
   logic            fall_s;
   logic [SW-1:0]   slot_next_s;
   logic            frame_start_s;
   logic            empty_s;
   logic            full_s;
   logic            push_s;
   logic            pop_s;
   logic [SLEN-1:0] word_s;
   logic [CW-1:0]   count_next_s;

   // Decode divider tick, BCLK fall event, frame start and FIFO push/pop.
   always_comb begin
      div_tick_s    = (div_cnt_r == DIV_LAST);
      fall_s        = div_tick_s & bclk_r;
      if (slot_r == SLOT_LAST) begin
         slot_next_s = {SW{1'b0}};
      end else begin
         slot_next_s = slot_r + SW'(1);
      end
      frame_start_s = fall_s & (slot_next_s == {SW{1'b0}});
      empty_s       = (count_r == {CW{1'b0}});
      full_s        = (count_r == CNT_FULL);
      // A full FIFO rejects the push even if a pop happens in the same cycle.
      push_s        = valid & ~full_s;
      // An empty FIFO cannot be popped even if a push lands in the same cycle.
      pop_s         = frame_start_s & ~empty_s;
      if (pop_s) begin
         word_s = mem_r[rd_ptr_r];
      end else begin
         word_s = last_r;
      end
   end

   // Next FIFO occupancy from the accepted push and pop.
   always_comb begin
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CW'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // System-clock divider producing the bit clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= {DW{1'b0}};
         bclk_r    <= 1'b0;
      end else if (div_tick_s) begin
         div_cnt_r <= {DW{1'b0}};
         bclk_r    <= ~bclk_r;
      end else begin
         div_cnt_r <= div_cnt_r + DW'(1);
      end
   end

   // Slot counter, word select, frame word load and serial shift on fall events.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_r     <= SLOT_LAST;
         lrclk_r    <= 1'b1;
         shift_r    <= {(FRAME + 1){1'b0}};
         last_r     <= {SLEN{1'b0}};
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= frame_start_s & empty_s;
         if (fall_s) begin
            slot_r  <= slot_next_s;
            lrclk_r <= (slot_next_s >= SLOT_R);
            if (frame_start_s) begin
               // Top bit keeps the previous word's LSB for the one-BCLK I2S delay.
               shift_r <= {shift_r[FRAME-1], word_s, word_s};
               last_r  <= word_s;
            end else begin
               shift_r <= {shift_r[FRAME-1:0], 1'b0};
            end
         end
      end
   end

   // FIFO pointers, occupancy and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         ready_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r    <= count_next_s;
         ready_r    <= (count_next_s != CNT_FULL);
         overflow_r <= valid & full_s;
      end
   end

   // FIFO storage write; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= i_sample;
      end
   end

   assign o_ready    = ready_r;
   assign o_bclk     = bclk_r;
   assign o_lrclk    = lrclk_r;
   assign o_sdata    = shift_r[FRAME];
   assign o_underrun = underrun_r;
   assign o_overflow = overflow_r;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: two instances (BCLK_DIV=2 and 1),
// an I2S receiver model feeding a received-word queue, and an expected queue.
module tb_i2s_tx_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] i_sample = 16'h0000;
   logic        sel = 1'b0;

   logic ready0, bclk0, lrclk0, sdata0, underrun0, overflow0;
   logic ready1, bclk1, lrclk1, sdata1, underrun1, overflow1;
   logic mon_ready, mon_bclk, mon_lrclk, mon_sdata, mon_underrun, mon_overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ur_cnt = 0;
   int ovf_cnt = 0;

   logic [15:0] rx_sr;
   int          rx_cnt;
   logic        rx_prev_lr;
   logic [16:0] rx_q [$];
   logic [16:0] exp_q [$];

   i2s_tx_serializer #(.SLEN(16), .BCLK_DIV(2), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst), .valid(valid), .i_sample(i_sample),
      .o_ready(ready0), .o_bclk(bclk0), .o_lrclk(lrclk0), .o_sdata(sdata0),
      .o_underrun(underrun0), .o_overflow(overflow0));

   i2s_tx_serializer #(.SLEN(16), .BCLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst(rst), .valid(valid), .i_sample(i_sample),
      .o_ready(ready1), .o_bclk(bclk1), .o_lrclk(lrclk1), .o_sdata(sdata1),
      .o_underrun(underrun1), .o_overflow(overflow1));

   assign mon_ready    = sel ? ready1    : ready0;
   assign mon_bclk     = sel ? bclk1     : bclk0;
   assign mon_lrclk    = sel ? lrclk1    : lrclk0;
   assign mon_sdata    = sel ? sdata1    : sdata0;
   assign mon_underrun = sel ? underrun1 : underrun0;
   assign mon_overflow = sel ? overflow1 : overflow0;

   // System clock.
   always #5 clk = ~clk;

   // Cycle counter: number of posedges since reset was released.
   always begin
      @(posedge clk);
      if (rst) cyc = 0;
      else cyc = cyc + 1;
   end

   // Pulse counters for underrun and overflow, sampled on the falling clock edge.
   always begin
      @(negedge clk);
      if (rst) begin
         ur_cnt = 0;
         ovf_cnt = 0;
      end else begin
         if (mon_underrun) ur_cnt = ur_cnt + 1;
         if (mon_overflow) ovf_cnt = ovf_cnt + 1;
      end
   end

   // I2S receiver model: samples data on BCLK rise; an LRCLK change marks the
   // LSB of the word for the previous channel.
   always begin
      @(posedge mon_bclk or posedge rst);
      if (rst) begin
         rx_q.delete();
         rx_cnt = 0;
         rx_prev_lr = 1'b1;
         rx_sr = 16'h0000;
      end else begin
         #1;
         rx_sr = {rx_sr[14:0], mon_sdata};
         rx_cnt = rx_cnt + 1;
         if (mon_lrclk != rx_prev_lr) begin
            if (rx_cnt >= 16) rx_q.push_back({rx_prev_lr, rx_sr});
            rx_cnt = 0;
            rx_prev_lr = mon_lrclk;
         end
      end
   end

   task automatic do_reset(input logic which);
      @(posedge clk); #1;
      rst = 1'b1;
      valid = 1'b0;
      sel = which;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      do_reset(1'b0);
      checks++; if (mon_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b want 0", mon_bclk); end
      checks++; if (mon_lrclk !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b want 1", mon_lrclk); end
      checks++; if (mon_sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", mon_sdata); end
      checks++; if (mon_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", mon_underrun); end
      checks++; if (mon_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", mon_overflow); end
      checks++; if (mon_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mon_ready); end
   endtask

   task automatic test_idle;
      int fall_cyc = 0, rise1 = 0, rise2 = 0, nr = 0, lr_bad = 0, sd_bad = 0, u1 = 0, u2 = 0;
      logic prev_b = 1'b0;
      do_reset(1'b0);
      for (int k = 0; k < 140; k++) begin
         step(1);
         if (prev_b && !mon_bclk && fall_cyc == 0) fall_cyc = cyc;
         if (!prev_b && mon_bclk) begin
            if (rise1 == 0) rise1 = cyc;
            else if (rise2 == 0) rise2 = cyc;
            if (fall_cyc != 0 && nr < 32) begin
               if (mon_lrclk !== (nr >= 16)) lr_bad++;
               nr++;
            end
         end
         if (mon_sdata !== 1'b0) sd_bad++;
         if (mon_underrun === 1'b1) begin
            if (u1 == 0) u1 = cyc;
            else if (u2 == 0) u2 = cyc;
         end
         prev_b = mon_bclk;
      end
      checks++; if (fall_cyc != 4) begin errors++; $display("FAIL idle_first_fall: got cycle %0d want 4", fall_cyc); end
      checks++; if (rise2 - rise1 != 4) begin errors++; $display("FAIL idle_bclk_period: got %0d want 4", rise2 - rise1); end
      checks++; if (lr_bad != 0 || nr != 32) begin errors++; $display("FAIL idle_lrclk: %0d bad of %0d slots, want 0 of 32", lr_bad, nr); end
      checks++; if (sd_bad != 0) begin errors++; $display("FAIL idle_sdata: got %0d nonzero cycles want 0", sd_bad); end
      checks++; if (u1 != 4) begin errors++; $display("FAIL idle_underrun_first: got cycle %0d want 4", u1); end
      checks++; if (u2 != 132) begin errors++; $display("FAIL idle_underrun_period: got cycle %0d want 132", u2); end
   endtask

   task automatic test_single;
      int idx = 0;
      logic [16:0] e;
      do_reset(1'b0);
      valid = 1'b1; i_sample = 16'hA5C3;
      exp_q.push_back({1'b0, 16'hA5C3});
      exp_q.push_back({1'b1, 16'hA5C3});
      step(1);
      valid = 1'b0;
      step(99);
      checks++; if (ur_cnt != 0) begin errors++; $display("FAIL single_no_underrun: got %0d pulses want 0", ur_cnt); end
      step(40);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (idx >= rx_q.size()) begin errors++; $display("FAIL single_rx[%0d]: nothing received, want %h", idx, e); end
         else if (rx_q[idx] !== e) begin errors++; $display("FAIL single_rx[%0d]: got %h want %h", idx, rx_q[idx], e); end
         idx++;
      end
   endtask

   task automatic test_back_to_back;
      int idx = 0;
      logic [16:0] e;
      do_reset(1'b0);
      valid = 1'b1; i_sample = 16'h8000;
      exp_q.push_back({1'b0, 16'h8000});
      exp_q.push_back({1'b1, 16'h8000});
      step(1);
      i_sample = 16'h0001;
      exp_q.push_back({1'b0, 16'h0001});
      exp_q.push_back({1'b1, 16'h0001});
      // With nothing more pushed, the third frame repeats the held word.
      exp_q.push_back({1'b0, 16'h0001});
      exp_q.push_back({1'b1, 16'h0001});
      step(1);
      valid = 1'b0;
      step(298);
      checks++; if (ur_cnt != 1) begin errors++; $display("FAIL b2b_underrun: got %0d pulses want 1", ur_cnt); end
      step(95);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (idx >= rx_q.size()) begin errors++; $display("FAIL b2b_rx[%0d]: nothing received, want %h", idx, e); end
         else if (rx_q[idx] !== e) begin errors++; $display("FAIL b2b_rx[%0d]: got %h want %h", idx, rx_q[idx], e); end
         idx++;
      end
   endtask

   task automatic test_overflow;
      int idx = 0;
      logic [16:0] e;
      do_reset(1'b0);
      // First frame (cycle 4) starts empty and carries the reset word 0.
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b1, 16'h0000});
      step(4);
      checks++; if (mon_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_before: got %b want 1", mon_ready); end
      for (int i = 0; i < 10; i++) begin
         valid = 1'b1;
         i_sample = 16'h1000 + 16'(i);
         if (i < 4) begin
            exp_q.push_back({1'b0, 16'h1000 + 16'(i)});
            exp_q.push_back({1'b1, 16'h1000 + 16'(i)});
         end
         step(1);
      end
      valid = 1'b0;
      checks++; if (mon_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_full: got %b want 0", mon_ready); end
      step(16);
      checks++; if (ovf_cnt != 6) begin errors++; $display("FAIL ovf_pulses: got %0d want 6", ovf_cnt); end
      step(630);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (idx >= rx_q.size()) begin errors++; $display("FAIL ovf_rx[%0d]: nothing received, want %h", idx, e); end
         else if (rx_q[idx] !== e) begin errors++; $display("FAIL ovf_rx[%0d]: got %h want %h", idx, rx_q[idx], e); end
         idx++;
      end
   endtask

   task automatic test_mid_reset;
      int ucyc = 0;
      do_reset(1'b0);
      valid = 1'b1; i_sample = 16'hFFFF;
      step(1);
      i_sample = 16'h1234;
      step(1);
      valid = 1'b0;
      step(35);
      checks++; if (mon_sdata !== 1'b1) begin errors++; $display("FAIL midrst_sdata_s8: got %b want 1", mon_sdata); end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checks++;
      if (mon_bclk !== 1'b0 || mon_lrclk !== 1'b1 || mon_sdata !== 1'b0 || mon_ready !== 1'b1
          || mon_underrun !== 1'b0 || mon_overflow !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got bclk=%b lr=%b sd=%b rdy=%b ur=%b ov=%b want 0 1 0 1 0 0",
                  mon_bclk, mon_lrclk, mon_sdata, mon_ready, mon_underrun, mon_overflow);
      end
      for (int k = 0; k < 12; k++) begin
         step(1);
         if (mon_underrun === 1'b1 && ucyc == 0) ucyc = cyc;
      end
      checks++; if (ucyc != 4) begin errors++; $display("FAIL midrst_next_frame: underrun at cycle %0d want 4", ucyc); end
   endtask

   task automatic test_random_div1;
      int idx = 0;
      logic [16:0] e;
      logic [15:0] w;
      do_reset(1'b1);
      for (int i = 0; i < 20; i++) begin
         w = 16'($urandom);
         exp_q.push_back({1'b0, w});
         exp_q.push_back({1'b1, w});
         valid = 1'b1; i_sample = w;
         step(1);
         valid = 1'b0;
         step(63);
      end
      checks++; if (ur_cnt != 0) begin errors++; $display("FAIL rand_underrun: got %0d pulses want 0", ur_cnt); end
      step(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (idx >= rx_q.size()) begin errors++; $display("FAIL rand_rx[%0d]: nothing received, want %h", idx, e); end
         else if (rx_q[idx] !== e) begin errors++; $display("FAIL rand_rx[%0d]: got %h want %h", idx, rx_q[idx], e); end
         idx++;
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      test_random_div1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
